uart_tx_unit: RTL and testbench



---
 rtl/uart_tx_unit.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, stop bits.
// Accepts one byte per request strobe; strobes that arrive while busy set a sticky overrun flag.
module uart_tx_unit #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       new_tx_data,
    output logic       tx_busy,
    output logic       tx,
    output logic       tx_done,
    output logic       overrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      DataLast = 3'(DATA_BITS - 1);
    localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);
    localparam logic [7:0]      DataMask = 8'((1 << DATA_BITS) - 1);
    localparam logic            OddPar   = (PARITY == 1);
    localparam logic            HasPar   = (PARITY != 0);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;
    logic            bit_end;
    logic [7:0]      masked;

    assign bit_end = (baud_q == CntLast);
    assign masked  = tx_data & DataMask;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        if (new_tx_data && busy_q) begin
            overrun_d = 1'b1;
        end

        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + CntW'(1);
        end

        // tx is registered, so each bit-end edge loads the level of the upcoming slot.
        case (state_q)
            StIdle: begin
                if (new_tx_data) begin
                    shift_d  = masked;
                    parity_d = (^masked) ^ OddPar;
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == DataLast) begin
                        bit_d = '0;
                        if (HasPar) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_q == StopLast) begin
                        state_d = StIdle;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: five instances (8N1, 8E1, 8O1, 8N2, 5N1) at 4 clocks per bit.
module tb_uart_tx_unit;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic [4:0] stb;
    logic [4:0] txw, busyw, donew, ovrw;

    int errors = 0;
    int checks = 0;

    logic tx_log   [0:127];
    logic busy_log [0:127];
    logic done_log [0:127];

    always #5 clk = ~clk;

    uart_tx_unit #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .new_tx_data(stb[0]),
        .tx_busy(busyw[0]), .tx(txw[0]), .tx_done(donew[0]), .overrun(ovrw[0]));
    uart_tx_unit #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .new_tx_data(stb[1]),
        .tx_busy(busyw[1]), .tx(txw[1]), .tx_done(donew[1]), .overrun(ovrw[1]));
    uart_tx_unit #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .new_tx_data(stb[2]),
        .tx_busy(busyw[2]), .tx(txw[2]), .tx_done(donew[2]), .overrun(ovrw[2]));
    uart_tx_unit #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .new_tx_data(stb[3]),
        .tx_busy(busyw[3]), .tx(txw[3]), .tx_done(donew[3]), .overrun(ovrw[3]));
    uart_tx_unit #(.CLKS_PER_BIT(C), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
        .clk(clk), .reset(reset), .tx_data(tx_data), .new_tx_data(stb[4]),
        .tx_busy(busyw[4]), .tx(txw[4]), .tx_done(donew[4]), .overrun(ovrw[4]));

    // Reference frame: level expected in a given bit slot.
    function automatic logic frame_bit(input logic [7:0] d, input int dbits, input int par,
                                       input int slot);
        logic p;
        p = 1'b0;
        if (slot == 0) return 1'b0;
        if (slot <= dbits) return d[slot-1];
        if (par != 0 && slot == dbits + 1) begin
            for (int i = 0; i < dbits; i++) p = p ^ d[i];
            return (par == 1) ? ~p : p;
        end
        return 1'b1;
    endfunction

    // Sample index n is the cycle right after edge E0+n; tx_data is scrambled after acceptance.
    task automatic capture(input int idx, input logic [7:0] data, input int inject_at,
                           input logic [7:0] inj_data);
        @(negedge clk);
        tx_data  = data;
        stb[idx] = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            tx_log[n]   = txw[idx];
            busy_log[n] = busyw[idx];
            done_log[n] = donew[idx];
            if (n == 0) tx_data = ~data;
            stb[idx] = (n + 1 == inject_at);
            if (n + 1 == inject_at) tx_data = inj_data;
        end
        stb[idx] = 1'b0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        stb     = '0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({txw, busyw, donew, ovrw} !== {5'h1f, 5'h00, 5'h00, 5'h00}) begin
            errors++;
            $display("FAIL reset_state: got tx=%b busy=%b done=%b ovr=%b want 11111/0/0/0",
                     txw, busyw, donew, ovrw);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_8n1;
        logic [9:0] exp_slots;
        int         nbusy, ndone;
        logic       bad;
        exp_slots = 10'b1101001010;
        capture(0, 8'hA5, -1, 8'h00);
        for (int s = 0; s < 10; s++) begin
            bad = 1'b0;
            for (int c = 0; c < C; c++) if (tx_log[s*C+c] !== exp_slots[s]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL a5_slot%0d: got %b%b%b%b want %b", s, tx_log[s*C], tx_log[s*C+1],
                         tx_log[s*C+2], tx_log[s*C+3], exp_slots[s]);
            end
        end
        nbusy = 0;
        ndone = 0;
        for (int n = 0; n < 64; n++) begin
            nbusy += int'(busy_log[n]);
            ndone += int'(done_log[n]);
        end
        checks++;
        if (nbusy != 40 || busy_log[39] !== 1'b1 || busy_log[40] !== 1'b0) begin
            errors++;
            $display("FAIL a5_busy: got %0d cycles want 40 ending at 40", nbusy);
        end
        checks++;
        if (ndone != 1 || done_log[40] !== 1'b1) begin
            errors++;
            $display("FAIL a5_done: got %0d pulses (at40=%b) want 1 at cycle 40", ndone,
                     done_log[40]);
        end
        checks++;
        if (tx_log[40] !== 1'b1 || ovrw[0] !== 1'b0) begin
            errors++;
            $display("FAIL a5_idle: got tx=%b ovr=%b want 1/0", tx_log[40], ovrw[0]);
        end
    endtask

    task automatic test_format(input string name, input int idx, input logic [7:0] data,
                               input int dbits, input int par, input int stops);
        int   nslots, f, nbusy, ndone;
        logic bad, e;
        nslots = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
        f      = nslots * C;
        capture(idx, data, -1, 8'h00);
        for (int s = 0; s < nslots; s++) begin
            e   = frame_bit(data, dbits, par, s);
            bad = 1'b0;
            for (int c = 0; c < C; c++) if (tx_log[s*C+c] !== e) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s_slot%0d: got %b%b%b%b want %b", name, s, tx_log[s*C],
                         tx_log[s*C+1], tx_log[s*C+2], tx_log[s*C+3], e);
            end
        end
        nbusy = 0;
        ndone = 0;
        for (int n = 0; n < 64; n++) begin
            nbusy += int'(busy_log[n]);
            ndone += int'(done_log[n]);
        end
        checks++;
        if (nbusy != f || done_log[f] !== 1'b1 || ndone != 1 || ovrw[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s_timing: got busy=%0d done=%0d ovr=%b want busy=%0d done=1 ovr=0",
                     name, nbusy, ndone, ovrw[idx], f);
        end
    endtask

    task automatic test_back_to_back;
        int   first_low, gap, wrong;
        logic sent2, e;
        first_low = -1;
        gap       = 0;
        sent2     = 1'b0;
        @(negedge clk);
        tx_data = 8'h11;
        stb[0]  = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            stb[0]      = 1'b0;
            tx_log[n]   = txw[0];
            busy_log[n] = busyw[0];
            if (n >= 1 && !sent2 && busyw[0] === 1'b0) begin
                first_low = n;
                sent2     = 1'b1;
                tx_data   = 8'h22;
                stb[0]    = 1'b1;
            end
        end
        stb[0] = 1'b0;
        wrong  = 0;
        for (int n = 0; n < 100; n++) begin
            if (n < 40) e = frame_bit(8'h11, 8, 0, n / C);
            else if (n == 40) e = 1'b1;
            else if (n <= 80) e = frame_bit(8'h22, 8, 0, (n - 41) / C);
            else e = 1'b1;
            if (tx_log[n] !== e) wrong++;
            if (n > 0 && n < 81 && busy_log[n] === 1'b0) gap++;
        end
        checks++;
        if (first_low != 40) begin
            errors++;
            $display("FAIL b2b_first_idle: got cycle %0d want 40", first_low);
        end
        checks++;
        if (wrong != 0) begin
            errors++;
            $display("FAIL b2b_waveform: got %0d wrong samples want 0", wrong);
        end
        checks++;
        if (gap != 1 || ovrw[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles ovr=%b want 1/0", gap, ovrw[0]);
        end
    endtask

    task automatic test_overrun;
        int   wrong, late_busy;
        logic e;
        capture(0, 8'h3C, 10, 8'hFF);
        wrong     = 0;
        late_busy = 0;
        for (int n = 0; n < 64; n++) begin
            e = (n < 40) ? frame_bit(8'h3C, 8, 0, n / C) : 1'b1;
            if (tx_log[n] !== e) wrong++;
            if (n >= 40 && busy_log[n] !== 1'b0) late_busy++;
        end
        checks++;
        if (wrong != 0 || late_busy != 0) begin
            errors++;
            $display("FAIL overrun_frame: got %0d wrong samples, %0d late busy want 0/0", wrong,
                     late_busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ovrw[0] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b want 1", ovrw[0]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int   wrong, nbusy;
        logic e;
        @(negedge clk);
        tx_data = 8'h00;
        stb[0]  = 1'b1;
        for (int n = 0; n < 17; n++) begin
            @(negedge clk);
            stb[0] = 1'b0;
        end
        checks++;
        if (txw[0] !== 1'b0 || busyw[0] !== 1'b1) begin
            errors++;
            $display("FAIL midframe_pre: got tx=%b busy=%b want 0/1", txw[0], busyw[0]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (txw[0] !== 1'b1 || busyw[0] !== 1'b0 || ovrw[0] !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got tx=%b busy=%b ovr=%b want 1/0/0", txw[0],
                     busyw[0], ovrw[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        capture(0, 8'h81, -1, 8'h00);
        wrong = 0;
        nbusy = 0;
        for (int n = 0; n < 64; n++) begin
            e = (n < 40) ? frame_bit(8'h81, 8, 0, n / C) : 1'b1;
            if (tx_log[n] !== e) wrong++;
            nbusy += int'(busy_log[n]);
        end
        checks++;
        if (wrong != 0 || nbusy != 40 || done_log[40] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_frame: got %0d wrong, busy=%0d want 0 wrong, busy=40",
                     wrong, nbusy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_format("e1_07", 1, 8'h07, 8, 2, 1);
        test_format("o1_07", 2, 8'h07, 8, 1, 1);
        test_format("n2_5a", 3, 8'h5A, 8, 0, 2);
        test_format("b5_ff", 4, 8'hFF, 5, 0, 1);
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
